// File: rtl/zwei_kanal_ram.sv
// zwei_kanal_ram: one word-addressed storage array shared by an instruction
// channel (read-only) and a data channel (read/write), with round-robin
// arbitration, a programmable access latency and level-request /
// pulse-acknowledge handshakes.
// Optional feature macro: HANS_RAM_INIT_EN adds a single-cycle init write
// port (InitSchreiben/InitAdresse/InitDaten) for preloading programs.
module zwei_kanal_ram #(
   parameter int WORDSIZE = 32,
   parameter int WORDS    = 256,
   parameter int LATENCY  = 2
) (
   input  logic                Clock,
   input  logic                Reset,
   input  logic                LeseInstruktion,
   input  logic [31:0]         InstruktionAdresse,
   output logic [WORDSIZE-1:0] Instruktion,
   output logic                InstruktionGeladen,
   input  logic                LeseDaten,
   input  logic                SchreibeDaten,
   input  logic [31:0]         DatenAdresse,
   input  logic [WORDSIZE-1:0] DatenRein,
   output logic [WORDSIZE-1:0] DatenRaus,
   output logic                DatenGeladen,
   output logic                DatenGespeichert
`ifdef HANS_RAM_INIT_EN
   ,
   input  logic                InitSchreiben,
   input  logic [31:0]         InitAdresse,
   input  logic [WORDSIZE-1:0] InitDaten
`endif
);

   localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   logic [WORDSIZE-1:0] mem [WORDS];

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                chan_q, chan_d;        // 1 = data channel owns the access
   logic                wr_q, wr_d;            // access is a write
   logic [AW-1:0]       addr_q, addr_d;
   logic [WORDSIZE-1:0] wdata_q, wdata_d;
   logic                last_data_q, last_data_d;  // round-robin: data granted last
   logic                ack_i_q, ack_dr_q, ack_dw_q;
   logic [WORDSIZE-1:0] instr_q, draus_q;

   logic                init_blk;
   logic                do_access;
   logic                req_i, req_d, grant_data;

`ifdef HANS_RAM_INIT_EN
   assign init_blk = InitSchreiben;
`else
   assign init_blk = 1'b0;
`endif

   // Upper address bits are deliberately ignored (addresses wrap modulo WORDS).
   generate
      if (AW < 32) begin : g_unused
`ifdef HANS_RAM_INIT_EN
         logic unused_addr_bits;
         assign unused_addr_bits = ^{InstruktionAdresse[31:AW], DatenAdresse[31:AW],
                                     InitAdresse[31:AW]};
`else
         logic unused_addr_bits;
         assign unused_addr_bits = ^{InstruktionAdresse[31:AW], DatenAdresse[31:AW]};
`endif
      end
   endgenerate

   assign req_i      = LeseInstruktion;
   assign req_d      = LeseDaten | SchreibeDaten;
   // Data wins only if it alone requests, or both request and instruction went last.
   assign grant_data = req_d & (~req_i | ~last_data_q);
   assign do_access  = (state_q == BUSY) && (cnt_q == 4'd0);

   // Next-state logic: arbitration and latching at grant, latency countdown, response.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      chan_d      = chan_q;
      wr_d        = wr_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      last_data_d = last_data_q;
      case (state_q)
         IDLE: begin
            if (!init_blk && (req_i || req_d)) begin
               chan_d  = grant_data;
               addr_d  = grant_data ? DatenAdresse[AW-1:0] : InstruktionAdresse[AW-1:0];
               wdata_d = DatenRein;
               wr_d    = grant_data & SchreibeDaten;
               cnt_d   = 4'(LATENCY - 1);
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (cnt_q == 4'd0) state_d = RESP;
            else               cnt_d   = cnt_q - 4'd1;
         end
         RESP: begin
            last_data_d = chan_q;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Control registers, acknowledge pulses and read-data holding registers.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         chan_q      <= 1'b0;
         wr_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         last_data_q <= 1'b1;
         ack_i_q     <= 1'b0;
         ack_dr_q    <= 1'b0;
         ack_dw_q    <= 1'b0;
         instr_q     <= '0;
         draus_q     <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         chan_q      <= chan_d;
         wr_q        <= wr_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         last_data_q <= last_data_d;
         ack_i_q     <= do_access & ~chan_q;
         ack_dr_q    <= do_access & chan_q & ~wr_q;
         ack_dw_q    <= do_access & chan_q & wr_q;
         if (do_access && !chan_q)         instr_q <= mem[addr_q];
         if (do_access && chan_q && !wr_q) draus_q <= mem[addr_q];
      end
   end

   // Array writes; the channel write comes last so it wins an address collision.
   always_ff @(posedge Clock) begin
`ifdef HANS_RAM_INIT_EN
      if (InitSchreiben) mem[InitAdresse[AW-1:0]] <= InitDaten;
`endif
      if (do_access && chan_q && wr_q && !Reset) mem[addr_q] <= wdata_q;
   end

   assign Instruktion        = instr_q;
   assign InstruktionGeladen = ack_i_q;
   assign DatenRaus          = draus_q;
   assign DatenGeladen       = ack_dr_q;
   assign DatenGespeichert   = ack_dw_q;

endmodule

// File: doc/zwei_kanal_ram.md
# zwei_kanal_ram

- Word-addressed synchronous RAM with two independent request channels sharing one storage array:
  - instruction channel (read-only);
  - data channel (read/write).
- Sits between the CPU's instruction and data ports, replacing two separate RAMs with one unified memory.
- Round-robin arbitration between the channels, configurable access latency, and a level-request / pulse-acknowledge handshake per channel.

## Interface
- WORDSIZE, 32: data word width in bits.
- WORDS, 256: number of words; address bits used = $clog2(WORDS), upper address bits ignored.
- LATENCY, 2: cycles from accepted request to acknowledge pulse; legal range 1..15.

- Clock  in  1  single clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high.
- LeseInstruktion  in  1  instruction read request (level).
- InstruktionAdresse  in  32  instruction word address.
- Instruktion  out  WORDSIZE  instruction read data.
- InstruktionGeladen  out  1  one-cycle pulse: Instruktion valid.
- LeseDaten  in  1  data read request (level).
- SchreibeDaten  in  1  data write request (level).
- DatenAdresse  in  32  data word address.
- DatenRein  in  WORDSIZE  write data.
- DatenRaus  out  WORDSIZE  data read result.
- DatenGeladen  out  1  one-cycle pulse: DatenRaus valid.
- DatenGespeichert  out  1  one-cycle pulse: write committed.

## Operation
- Reset values:
  - all outputs 0;
  - state IDLE;
  - round-robin pointer = "data granted last", so the instruction channel wins the first tie.
- Reset does not clear the memory array.
- States:
  - IDLE: sample requests. If none are pending, stay. If one channel is pending, grant it. If both are pending, grant the channel not granted last. Latch channel, address, write data and op, load counter = LATENCY-1, go to BUSY.
  - BUSY: decrement the counter. At 0, perform the access (read array, or write array) and go to RESP.
  - RESP: assert exactly one acknowledge for one cycle, update the round-robin pointer, return to IDLE.
- Data channel with LeseDaten and SchreibeDaten both high: write only. DatenGespeichert pulses; DatenGeladen stays 0; DatenRaus is unchanged.
- Requests are levels; the requester holds its request until its acknowledge. A request still high in the cycle after the acknowledge is a new access.
- Address and write data are latched at grant; later changes do not affect the access in flight.
- Instruktion and DatenRaus hold their last read value until the next read on that channel.
- Reset mid-access: the access is aborted, no acknowledge is issued, and a pending write is not committed.

## Timing
- Request high before edge k while IDLE: grant at edge k.
  - Array access and the acknowledge register are updated at edge k+LATENCY.
  - The acknowledge and the read data are visible in the cycle after edge k+LATENCY.
  - The acknowledge drops at edge k+LATENCY+1, with the return to IDLE.
- Minimum spacing between grants: LATENCY+2 cycles.
- Under continuous contention the channels alternate strictly: I, D, I, D…
- Only one acknowledge may be high in any cycle.

## Configuration
- HANS_RAM_INIT_EN defined: adds the init port, used by benches to load programs before releasing the CPU's Reset.
  - Ports:
    - InitSchreiben  in  1;
    - InitAdresse  in  32;
    - InitDaten  in  WORDSIZE.
  - InitSchreiben high at an edge writes InitDaten immediately, in a single cycle, in any state, including during Reset.
  - While InitSchreiben is high, IDLE grants nothing.
  - An access already in flight completes normally; its later write wins on an address collision.
- Not defined: the init ports are absent and the array is written only through the data channel.

## Test plan
- Write then read, LATENCY=2: SchreibeDaten with address 5 and data 0xDEADBEEF → DatenGespeichert pulses 3 cycles after grant. LeseDaten at address 5 → DatenGeladen pulse, DatenRaus = 0xDEADBEEF.
- Contention: LeseInstruktion and LeseDaten held continuously from reset → acknowledges alternate I, D, I, D, each LATENCY+2 cycles apart, never two in one cycle.
- Read+write collision: LeseDaten and SchreibeDaten both high, address 7, data 0x12 → only DatenGespeichert pulses; DatenRaus is unchanged; a subsequent read of address 7 returns 0x12.
- Reset abort: Reset asserted one cycle into a write of 0xAA to address 3 (old value 0x55) → no acknowledge; address 3 still reads 0x55.
- Address wrap, WORDS=256: write 0x77 to address 0x105 → a read of address 0x05 returns 0x77.
- HANS_RAM_INIT_EN: load 7 words via the init port under Reset, release Reset, instruction-read addresses 0..6 → the loaded words come back in order.
